// File: rtl/instruction_memory_loader.sv
// instruction_memory_loader: turns a byte stream (length word N, then N little-endian words) into instruction memory writes
// Ports: clk, reset (async, active-high), start (load request pulse),
//        byte_valid/byte_data/byte_ready (byte stream handshake; transfer = byte_valid & byte_ready),
//        wr_en/wr_address/wr_data (one-cycle memory write; byte address),
//        busy (load in progress, holds the CPU), done/error (sticky result of the last load).
// Build option LOADER_CHECKSUM_EN: a trailing 4-byte word must equal the XOR of all data words.
module instruction_memory_loader #(
   parameter int INSTRUCTION_BITSIZE      = 32,
   parameter int INSTRUCTION_MEMORY_DEPTH = 256,
   parameter int BASE_ADDRESS             = 0
)(
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic                           byte_valid,
   input  logic [7:0]                     byte_data,
   output logic                           byte_ready,
   output logic                           wr_en,
   output logic [31:0]                    wr_address,
   output logic [INSTRUCTION_BITSIZE-1:0] wr_data,
   output logic                           busy,
   output logic                           done,
   output logic                           error
);
   localparam int CW = $clog2(INSTRUCTION_MEMORY_DEPTH) + 1;
   localparam logic [31:0] LIMIT = 32'(INSTRUCTION_MEMORY_DEPTH - BASE_ADDRESS / 4);
`ifdef LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, LEN, DATA, CHK, DONE, ERROR} state_t;
   logic [31:0] xor_acc;
`else
   typedef enum logic [2:0] {IDLE, LEN, DATA, DONE, ERROR} state_t;
`endif
   state_t      state;
   logic [1:0]  byte_cnt;
   logic [CW-1:0] word_cnt;
   logic [31:0] len;
   logic [23:0] shift;
   logic [31:0] word;
   logic        take;
`ifdef LOADER_CHECKSUM_EN
   assign busy = state == LEN || state == DATA || state == CHK;
`else
   assign busy = state == LEN || state == DATA;
`endif
   assign byte_ready = busy;
   assign take       = byte_valid & byte_ready;
   // the incoming byte is the most significant one of the word being assembled
   assign word       = {byte_data, shift};
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         byte_cnt   <= '0;
         word_cnt   <= '0;
         len        <= '0;
         shift      <= '0;
         wr_en      <= 1'b0;
         wr_address <= '0;
         wr_data    <= '0;
         done       <= 1'b0;
         error      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         xor_acc    <= '0;
`endif
      end else begin
         wr_en <= 1'b0;
         case (state)
            IDLE, DONE, ERROR: if (start) begin
               state    <= LEN;
               done     <= 1'b0;
               error    <= 1'b0;
               byte_cnt <= '0;
               word_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
               xor_acc  <= '0;
`endif
            end
            default: if (take) begin
               byte_cnt <= byte_cnt + 2'd1;
               shift    <= word[31:8];
               if (byte_cnt == 2'd3) begin
                  case (state)
                     LEN: begin
                        len <= word;
                        if (word == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                           state <= CHK;
`else
                           state <= DONE;
                           done  <= 1'b1;
`endif
                        end else if (word > LIMIT) begin
                           state <= ERROR;
                           error <= 1'b1;
                        end else state <= DATA;
                     end
                     DATA: begin
                        wr_en      <= 1'b1;
                        wr_address <= 32'(BASE_ADDRESS) + 32'({word_cnt, 2'b00});
                        wr_data    <= word;
                        word_cnt   <= word_cnt + CW'(1);
`ifdef LOADER_CHECKSUM_EN
                        xor_acc    <= xor_acc ^ word;
                        if (32'(word_cnt) + 32'd1 == len) state <= CHK;
`else
                        if (32'(word_cnt) + 32'd1 == len) begin
                           state <= DONE;
                           done  <= 1'b1;
                        end
`endif
                     end
`ifdef LOADER_CHECKSUM_EN
                     CHK: begin
                        state <= word == xor_acc ? DONE : ERROR;
                        done  <= word == xor_acc;
                        error <= word != xor_acc;
                     end
`endif
                     default: ;
                  endcase
               end
            end
         endcase
      end
   end
endmodule
